toggle_pulse_gen: RTL and testbench
===================================

TOGGLE_PULSE_GEN -- requirements
Module: toggle_pulse_gen

Interface
REQ-001 Parameter WIDTH, default 8: width of period, burst and pulse_cnt.
REQ-002 clk, input, 1: single clock; all state updates on posedge clk.
REQ-003 reset, input, 1: asynchronous, active-low reset.
REQ-004 start, input, 1: request to begin a run, sampled in IDLE only.
REQ-005 stop, input, 1: abort the current run.
REQ-006 period, input, WIDTH: cycles between toggle pulses; 0 is treated as 1.
REQ-007 burst, input, WIDTH: pulses per run; 0 means continuous until stop.
REQ-008 t, output, 1: registered one-cycle toggle-enable pulse, driving a downstream T flip-flop t input.
REQ-009 busy, output, 1: high while in RUN.
REQ-010 done, output, 1: one-cycle pulse when a finite burst completes.
REQ-011 pulse_cnt, output, WIDTH: pulses emitted in the current or last run.

Function
REQ-012 FSM states: IDLE, RUN, DONE.
REQ-013 IDLE -> RUN on start=1 and stop=0; period and burst are latched at that edge (edge k); pulse_cnt clears to 0.
REQ-014 start=1 together with stop=1 in IDLE: remain in IDLE, nothing is latched.
REQ-015 In RUN, t is high for exactly one cycle starting at edge k+P, then at every P edges after that (P = latched period, with 0 mapped to 1).
REQ-016 P=1: t is high on every cycle of RUN.
REQ-017 pulse_cnt increments at each edge that asserts t; it wraps modulo 2^WIDTH when burst=0.
REQ-018 The burst-th pulse asserts t; at the next edge the FSM enters DONE, t=0, done=1 for one cycle, and busy=0.
REQ-019 DONE -> IDLE unconditionally on the next edge; start in DONE is ignored.
REQ-020 stop=1 in RUN -> IDLE at the next edge; t=0 from that edge; done is not asserted; pulse_cnt holds its value.
REQ-021 stop on the same edge that would assert t: stop wins, and no pulse is issued.
REQ-022 start while in RUN is ignored; changes to period or burst inputs during RUN are ignored.

Reset
REQ-023 reset=0 forces IDLE immediately (asynchronously): t=0, busy=0, done=0, pulse_cnt=0, divider counter=0.
REQ-024 Reset asserted mid-run aborts the run without a done pulse; operation resumes only on a fresh start after reset deasserts.

Configuration
REQ-025 Macro TOGGLE_PULSE_GEN_ERR_EN, when defined, adds output err (1 bit): a one-cycle pulse on start during RUN or DONE, or on start with period=0; err resets to 0.
REQ-026 Without TOGGLE_PULSE_GEN_ERR_EN, port err does not exist and the same conditions are silently ignored or handled as in REQ-006, REQ-019 and REQ-022.

Structure
REQ-027 Package toggle_pulse_gen_pkg holds the FSM state enum (IDLE, RUN, DONE) and the WIDTH default constant.
REQ-028 One sub-module, tpg_divider: a loadable down-counter that takes a load value and an enable and emits a terminal-count strobe; the top module holds the FSM and pulse_cnt.

Verification
REQ-029 period=3, burst=4, start at edge 0 -> t high at edges 3, 6, 9, 12; done at edge 13; pulse_cnt=4; a downstream T-FF q toggles 4 times and ends at 0.
REQ-030 period=0, burst=2 -> t high at edges 1 and 2; done at edge 3.
REQ-031 period=2, burst=0, stop at edge 7 -> t at edges 2, 4, 6; IDLE at edge 8; no done; pulse_cnt=3.
REQ-032 period=4, burst=0, stop asserted on edge 8 (a pulse edge) -> t only at edge 4; pulse_cnt=1.
REQ-033 reset=0 asynchronously between edges 5 and 6 of a period=2 run -> t, busy and pulse_cnt are 0 immediately; start plus stop together afterwards keeps the FSM in IDLE.
REQ-034 With TOGGLE_PULSE_GEN_ERR_EN defined: start during RUN -> err=1 for one cycle; the run continues unaffected.

Source files
------------

// File: rtl/toggle_pulse_gen_pkg.sv
// toggle_pulse_gen_pkg: shared types and constants for the toggle pulse generator.
// Holds the run-control FSM state encoding and the default counter width.
package toggle_pulse_gen_pkg;

  // Default width of period, burst and pulse_cnt.
  localparam int TPG_WIDTH_DEFAULT = 8;

  // Run-control FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } tpg_state_t;

endpackage

// File: rtl/tpg_divider.sv
// tpg_divider: loadable down-counter used as the pulse-period divider.
// A load captures the reload value and presets the count; while enabled the
// counter decrements and, on reaching zero, raises tc and reloads.
module tpg_divider
  import toggle_pulse_gen_pkg::*;
#(
  parameter int WIDTH = TPG_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,     // asynchronous, active low
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,  // period minus one
  input  logic             en,
  output logic             tc
);

  logic [WIDTH-1:0] reload_q, reload_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;

  // Terminal count is only meaningful while the divider is running.
  assign tc = en && (cnt_q == '0);

  // Next-count logic: load has priority, otherwise count down and wrap to the reload value.
  always_comb begin
    reload_d = reload_q;
    cnt_d    = cnt_q;
    if (load) begin
      reload_d = load_val;
      cnt_d    = load_val;
    end else if (en) begin
      if (cnt_q == '0) begin
        cnt_d = reload_q;
      end else begin
        cnt_d = cnt_q - WIDTH'(1);
      end
    end
  end

  // Counter and reload registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      reload_q <= '0;
      cnt_q    <= '0;
    end else begin
      reload_q <= reload_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/toggle_pulse_gen.sv
// toggle_pulse_gen: emits one-cycle toggle-enable pulses every `period` cycles,
// for `burst` pulses (or forever when burst is 0) until stopped.
// Optional macro TOGGLE_PULSE_GEN_ERR_EN adds an `err` output that pulses on
// a start request during RUN or DONE, or on a start with period equal to 0.
module toggle_pulse_gen
  import toggle_pulse_gen_pkg::*;
#(
  parameter int WIDTH = TPG_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,     // asynchronous, active low
  input  logic             start,
  input  logic             stop,
  input  logic [WIDTH-1:0] period,
  input  logic [WIDTH-1:0] burst,
  output logic             t,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] pulse_cnt
`ifdef TOGGLE_PULSE_GEN_ERR_EN
  ,
  output logic             err
`endif
);

  tpg_state_t       state_q, state_d;
  logic [WIDTH-1:0] burst_q, burst_d;
  logic [WIDTH-1:0] pulse_cnt_q, pulse_cnt_d;
  logic             t_q, t_d;
  logic             done_q, done_d;

  logic             div_load;
  logic             div_en;
  logic             div_tc;
  logic [WIDTH-1:0] period_m1;

  // A period of 0 behaves like 1, so both reload the divider with 0.
  assign period_m1 = (period == '0) ? '0 : (period - WIDTH'(1));
  assign div_en    = (state_q == RUN);

  tpg_divider #(
    .WIDTH(WIDTH)
  ) u_divider (
    .clk     (clk),
    .reset   (reset),
    .load    (div_load),
    .load_val(period_m1),
    .en      (div_en),
    .tc      (div_tc)
  );

  // FSM next state and pulse generation; stop outranks completion and pulses.
  always_comb begin
    state_d     = state_q;
    burst_d     = burst_q;
    pulse_cnt_d = pulse_cnt_q;
    t_d         = 1'b0;
    done_d      = 1'b0;
    div_load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          state_d     = RUN;
          burst_d     = burst;
          pulse_cnt_d = '0;
          div_load    = 1'b1;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
        end else if ((burst_q != '0) && (pulse_cnt_q == burst_q)) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else if (div_tc) begin
          t_d         = 1'b1;
          pulse_cnt_d = pulse_cnt_q + WIDTH'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, latched burst, pulse counter and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      burst_q     <= '0;
      pulse_cnt_q <= '0;
      t_q         <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      burst_q     <= burst_d;
      pulse_cnt_q <= pulse_cnt_d;
      t_q         <= t_d;
      done_q      <= done_d;
    end
  end

  assign t         = t_q;
  assign done      = done_q;
  assign busy      = (state_q == RUN);
  assign pulse_cnt = pulse_cnt_q;

`ifdef TOGGLE_PULSE_GEN_ERR_EN
  logic err_q, err_d;

  // Flag start requests that cannot be honoured as given.
  always_comb begin
    err_d = start && ((state_q != IDLE) || (period == '0));
  end

  // Registered one-cycle error pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_toggle_pulse_gen.sv
// tb_toggle_pulse_gen: scoreboard bench for toggle_pulse_gen. Expected outputs
// for each clock edge are derived from closed-form pulse timing, queued when
// the stimulus for that edge is driven, and compared just after the edge.
module tb_toggle_pulse_gen;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         stop;
  logic [W-1:0] period;
  logic [W-1:0] burst;
  logic         t;
  logic         busy;
  logic         done;
  logic [W-1:0] pulse_cnt;
`ifdef TOGGLE_PULSE_GEN_ERR_EN
  logic         err;
`endif

  typedef struct {
    string tag;
    bit    t;
    bit    done;
    bit    busy;
    int    cnt;
    bit    err;
  } exp_s;

  exp_s exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  toggle_pulse_gen #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .stop     (stop),
    .period   (period),
    .burst    (burst),
    .t        (t),
    .busy     (busy),
    .done     (done),
    .pulse_cnt(pulse_cnt)
`ifdef TOGGLE_PULSE_GEN_ERR_EN
    ,
    .err      (err)
`endif
  );

  always #5 clk = ~clk;

  // Downstream T flip-flop driven by t, plus a count of its toggles.
  logic tff_q;
  int   tgl_cnt = 0;
  always @(posedge clk or negedge reset) begin
    if (!reset) tff_q <= 1'b0;
    else if (t) tff_q <= ~tff_q;
  end
  always @(posedge clk) begin
    if (reset && t) tgl_cnt <= tgl_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Scoreboard consumer: compare just after each active edge.
  always @(posedge clk) begin : mon
    exp_s x;
    #1;
    if (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      check({x.tag, "_t"},    32'(t),         32'(x.t));
      check({x.tag, "_done"}, 32'(done),      32'(x.done));
      check({x.tag, "_busy"}, 32'(busy),      32'(x.busy));
      check({x.tag, "_cnt"},  32'(pulse_cnt), 32'(x.cnt));
`ifdef TOGGLE_PULSE_GEN_ERR_EN
      check({x.tag, "_err"},  32'(err),       32'(x.err));
`endif
    end
  end

  // Expected outputs right after edge e of a run started at edge 0.
  function automatic exp_s exp_at(string tag, int p, int b, int stop_e, int e);
    exp_s r;
    int   pe      = (p == 0) ? 1 : p;
    int   lp      = b * pe;
    bit   stopped = (stop_e >= 0) && (e >= stop_e);
    int   e_eff   = stopped ? (stop_e - 1) : e;
    int   n;
    r.tag  = $sformatf("%s_e%0d", tag, e);
    r.t    = !stopped && (e >= pe) && (e % pe == 0) && (b == 0 || e <= lp);
    r.done = (b > 0) && !stopped && (e == lp + 1);
    r.busy = !stopped && (b == 0 || e <= lp);
    n = e_eff / pe;
    if (b > 0 && n > b) n = b;
    r.cnt = n % 256;
    r.err = 1'b0;
    return r;
  endfunction

  function automatic exp_s exp_idle(string tag, int cnt);
    exp_s r;
    r.tag  = tag;
    r.t    = 1'b0;
    r.done = 1'b0;
    r.busy = 1'b0;
    r.cnt  = cnt;
    r.err  = 1'b0;
    return r;
  endfunction

  // Drive inputs for the next edge and queue what that edge must produce.
  task automatic step(input bit st, input bit sp, input exp_s x);
    @(negedge clk);
    start = st;
    stop  = sp;
    exp_q.push_back(x);
    @(posedge clk);
  endtask

  // One run: start at edge 0, stray starts in RUN and DONE, optional stop.
  task automatic run_case(input string tag, input int p, input int b, input int stop_e);
    int   pe  = (p == 0) ? 1 : p;
    int   lp  = b * pe;
    int   n_e = (b > 0) ? (lp + 3) : (stop_e + 2);
    exp_s x;
    bit   st;
    @(negedge clk);
    period = W'(p);
    burst  = W'(b);
    x = exp_at(tag, p, b, stop_e, 0);
    x.err = (p == 0);
    step(1'b1, 1'b0, x);
    #2;
    period = W'($urandom);
    burst  = W'($urandom);
    for (int e = 1; e <= n_e; e++) begin
      st = (e == 1) || (b > 0 && e == lp + 2);
      x = exp_at(tag, p, b, stop_e, e);
      x.err = st;
      step(st, (e == stop_e), x);
    end
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    $display("[TB] case %s period=%0d burst=%0d stop_edge=%0d pulse_cnt=%0d", tag, p, b, stop_e, pulse_cnt);
  endtask

  initial begin : drive
    int   tg0;
    exp_s x;
    reset  = 1'b0;
    start  = 1'b0;
    stop   = 1'b0;
    period = '0;
    burst  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_t",    32'(t),         0);
    check("rst_busy", 32'(busy),      0);
    check("rst_done", 32'(done),      0);
    check("rst_cnt",  32'(pulse_cnt), 0);
    @(negedge clk);
    reset = 1'b1;

    tg0 = tgl_cnt;
    run_case("p3b4", 3, 4, -1);
    check("p3b4_tff_q",   32'(tff_q), 0);
    check("p3b4_toggles", 32'(tgl_cnt - tg0), 4);

    run_case("p0b2", 0, 2, -1);
    run_case("p2stop", 2, 0, 8);
    run_case("p4stop", 4, 0, 8);
    run_case("p5b1", 5, 1, -1);
    run_case("wrap", 1, 0, 260);

    // Reset in the middle of a period=2 continuous run.
    @(negedge clk);
    period = W'(2);
    burst  = '0;
    step(1'b1, 1'b0, exp_at("rstrun", 2, 0, -1, 0));
    for (int e = 1; e <= 5; e++) begin
      step(1'b0, 1'b0, exp_at("rstrun", 2, 0, -1, e));
    end
    #3;
    reset = 1'b0;
    #1;
    check("arst_t",    32'(t),         0);
    check("arst_busy", 32'(busy),      0);
    check("arst_done", 32'(done),      0);
    check("arst_cnt",  32'(pulse_cnt), 0);
    step(1'b0, 1'b0, exp_idle("arst_hold", 0));
    @(negedge clk);
    reset = 1'b1;
    x = exp_idle("startstop", 0);
    step(1'b1, 1'b1, x);
    step(1'b0, 1'b0, exp_idle("idle_after", 0));
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    $display("[TB] case rstrun async reset mid-run then start+stop in IDLE");

    repeat (2) @(posedge clk);
    #2;
    check("queue_drained", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
